weight_block_loader: RTL
========================

Name: weight_block_loader

Overview:
- Parametrised loader that gathers ARR_N rows of one weight block from a stream of wide SRAM words.
- Assembles them in a shadow register, then presents the complete block to the systolic array through a valid/ready handshake.
- Double-buffered: the next block can load while the array still holds the current one.
- Sits between the SRAM read path and the systolic MAC array's weight input.

Parameters:
- ELEM_W, 8, bits per weight element
- ARR_N, 4, array dimension; rows per block and elements per row
- SRAM_W, 64, SRAM word width; must be an integer multiple of ROW_W = ARR_N*ELEM_W
- Derived, not overridable: SLICES = SRAM_W/ROW_W; SEL_W = max(1, clog2(SLICES)); BLK_W = ARR_N*ROW_W

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- START  in  1  begin loading a new block; latches ORDER and SLICE_SEL
- ORDER  in  4  block tag, forwarded with the block
- SLICE_SEL  in  SEL_W  which ROW_W slice of each SRAM word is used
- SRAM_DATA  in  SRAM_W  SRAM read data
- SRAM_VALID  in  1  SRAM_DATA holds one row beat this cycle
- LOAD_BUSY  out  1  high in LOAD or PEND
- BLK_VALID  out  1  BLOCK_W/BLOCK_ORDER hold an unconsumed block
- BLK_READY  in  1  array accepts the block
- BLOCK_W  out  BLK_W  active weight block; row 0 in the MSBs
- BLOCK_ORDER  out  4  tag of the block in BLOCK_W
- ERR_START  out  1  sticky: START arrived while LOAD or PEND

Behaviour:
- Reset (RST sampled high at an edge), from any state including mid-load:
  - state=IDLE, row counter=0, shadow=0
  - BLOCK_W=0, BLOCK_ORDER=0, BLK_VALID=0, LOAD_BUSY=0, ERR_START=0
- Slice mapping: slice s = SRAM_DATA[SRAM_W-1-s*ROW_W -: ROW_W].
  - s=0 is the upper slice.
  - SLICE_SEL >= SLICES is treated as 0.
- Row mapping: beat r (0..ARR_N-1) writes shadow[BLK_W-1-r*ROW_W -: ROW_W].
  - Element c of a row sits at [ROW_W-1-c*ELEM_W -: ELEM_W].
- FSM IDLE / LOAD / PEND:
  - IDLE:
    - START: latch ORDER/SLICE_SEL, counter=0, go to LOAD.
    - SRAM_VALID is ignored, including in the START cycle.
  - LOAD:
    - Each SRAM_VALID cycle writes the selected slice to row[counter], then counter+1.
    - The beat with counter==ARR_N-1 moves to PEND; counter wraps to 0.
    - No SRAM_VALID: hold.
  - LOAD + START:
    - Restart: counter=0, relatch ORDER/SLICE_SEL, set ERR_START.
    - A beat in the same cycle is dropped.
    - Shadow rows are overwritten by new beats, not cleared.
  - PEND:
    - Transfer when !BLK_VALID, or BLK_VALID && BLK_READY in the same cycle.
    - Transfer at that edge: BLOCK_W<=shadow, BLOCK_ORDER<=latched ORDER, BLK_VALID<=1, go to IDLE.
    - Otherwise hold. SRAM_VALID is ignored.
    - START in PEND is ignored and sets ERR_START.
- Consumer side: BLK_VALID && BLK_READY with no transfer that cycle clears BLK_VALID. BLOCK_W keeps its value after acceptance.
- BLK_READY while !BLK_VALID has no effect.
- Latency: last beat sampled at edge k → PEND after k; with the slot free, BLK_VALID=1 and the new BLOCK_W are visible after edge k+1.
- Minimum load: ARR_N beats, one per cycle, back-to-back.
- LOAD_BUSY is registered and equals (state != IDLE).
- ERR_START clears only on RST.

Optional Feature:
- Macro WDL_TRANSPOSE_EN.
- Defined: row beat r, element c is written to shadow row c, element position r (block stored transposed, column-major feed). All other timing is identical.
- Undefined: row-major mapping as above.

Test Plan:
- Normal load (ARR_N=4, ELEM_W=8, SRAM_W=64, SLICE_SEL=0, ORDER=3):
  - Stimulus: START, then 4 back-to-back beats with upper halves 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Response: BLOCK_W=0x11111111_22222222_33333333_44444444, BLOCK_ORDER=3, BLK_VALID one cycle after PEND.
- Slice select: same stimulus with SLICE_SEL=1 and lower halves 0xA0A0A0A0.. 0xD0D0D0D0 → lower halves captured; upper halves ignored.
- Back-pressure:
  - Block A valid with BLK_READY=0, block B fully loaded → PEND holds, BLOCK_W stays A.
  - Raise BLK_READY for one cycle → B transfers at that edge; BLK_VALID stays 1.
- Gapped beats and restart:
  - SRAM_VALID gaps between beats → same result as back-to-back.
  - START after 2 beats → ERR_START=1, counter restarts, next 4 beats form the block.
- Reset mid-load: RST high after 2 beats → all outputs 0, IDLE; a later full load completes normally.
- WDL_TRANSPOSE_EN: rows 0x00010203, 0x10111213, 0x20212223, 0x30313233 → BLOCK_W rows 0x00102030, 0x01112131, 0x02122232, 0x03132333.

Source files
------------

// File: rtl/weight_block_loader_if.sv
// Handshake and data bundle between the SRAM read path, the weight block loader
// and the systolic array weight input. The loader uses the slave modport.
interface weight_block_loader_if #(
    parameter int ELEM_W = 8,
    parameter int ARR_N  = 4,
    parameter int SRAM_W = 64
);
    localparam int ROW_W  = ARR_N * ELEM_W;
    localparam int SLICES = SRAM_W / ROW_W;
    localparam int SEL_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int BLK_W  = ARR_N * ROW_W;

    logic              START;
    logic [3:0]        ORDER;
    logic [SEL_W-1:0]  SLICE_SEL;
    logic [SRAM_W-1:0] SRAM_DATA;
    logic              SRAM_VALID;
    logic              LOAD_BUSY;
    logic              BLK_VALID;
    logic              BLK_READY;
    logic [BLK_W-1:0]  BLOCK_W;
    logic [3:0]        BLOCK_ORDER;
    logic              ERR_START;

    modport master (
        output START, ORDER, SLICE_SEL, SRAM_DATA, SRAM_VALID, BLK_READY,
        input  LOAD_BUSY, BLK_VALID, BLOCK_W, BLOCK_ORDER, ERR_START
    );

    modport slave (
        input  START, ORDER, SLICE_SEL, SRAM_DATA, SRAM_VALID, BLK_READY,
        output LOAD_BUSY, BLK_VALID, BLOCK_W, BLOCK_ORDER, ERR_START
    );
endinterface

// File: rtl/weight_block_loader.sv
// Gathers ARR_N rows of a weight block into a shadow register and hands complete blocks
// to the systolic array through a double-buffered valid/ready slot.
// Optional macro WDL_TRANSPOSE_EN stores each block transposed (column-major feed).
module weight_block_loader #(
    parameter int ELEM_W = 8,
    parameter int ARR_N  = 4,
    parameter int SRAM_W = 64
) (
    input logic                  CLK,
    input logic                  RST,
    weight_block_loader_if.slave bus
);
    localparam int ROW_W  = ARR_N * ELEM_W;
    localparam int SLICES = SRAM_W / ROW_W;
    localparam int SEL_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int BLK_W  = ARR_N * ROW_W;
    localparam int CNT_W  = (ARR_N > 1) ? $clog2(ARR_N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [BLK_W-1:0]   shadow_q,      shadow_d;
    logic [3:0]         order_lat_q,   order_lat_d;
    logic [SEL_W-1:0]   sel_lat_q,     sel_lat_d;
    logic [BLK_W-1:0]   block_w_q,     block_w_d;
    logic [3:0]         block_order_q, block_order_d;
    logic               blk_valid_q,   blk_valid_d;
    logic               load_busy_q,   load_busy_d;
    logic               err_start_q,   err_start_d;

    logic [31:0]        slice_idx_s;
    logic [ROW_W-1:0]   row_s;
    logic               transfer_s;

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        order_lat_d   = order_lat_q;
        sel_lat_d     = sel_lat_q;
        block_w_d     = block_w_q;
        block_order_d = block_order_q;
        blk_valid_d   = blk_valid_q;
        err_start_d   = err_start_q;

        // Out-of-range selectors fall back to the upper slice.
        slice_idx_s = (32'(sel_lat_q) >= 32'(SLICES)) ? 32'd0 : 32'(sel_lat_q);
        row_s       = ROW_W'(bus.SRAM_DATA >> ((32'(SLICES) - 32'd1 - slice_idx_s) * 32'(ROW_W)));
        transfer_s  = (state_q == ST_PEND) && (!blk_valid_q || bus.BLK_READY);

        if (blk_valid_q && bus.BLK_READY) begin
            blk_valid_d = 1'b0;
        end else begin
            blk_valid_d = blk_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    order_lat_d = bus.ORDER;
                    sel_lat_d   = bus.SLICE_SEL;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.START) begin
                    // Restart drops any beat arriving in the same cycle.
                    order_lat_d = bus.ORDER;
                    sel_lat_d   = bus.SLICE_SEL;
                    cnt_d       = {CNT_W{1'b0}};
                    err_start_d = 1'b1;
                end else if (bus.SRAM_VALID) begin
`ifdef WDL_TRANSPOSE_EN
                    for (int c = 0; c < ARR_N; c++) begin
                        shadow_d[BLK_W-1-c*ROW_W-int'(cnt_q)*ELEM_W -: ELEM_W] =
                            row_s[ROW_W-1-c*ELEM_W -: ELEM_W];
                    end
`else
                    shadow_d[BLK_W-1-int'(cnt_q)*ROW_W -: ROW_W] = row_s;
`endif
                    if (cnt_q == CNT_W'(ARR_N - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_PEND;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_PEND: begin
                if (bus.START) begin
                    err_start_d = 1'b1;
                end else begin
                    err_start_d = err_start_q;
                end
                if (transfer_s) begin
                    block_w_d     = shadow_q;
                    block_order_d = order_lat_q;
                    blk_valid_d   = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        load_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            shadow_q      <= {BLK_W{1'b0}};
            order_lat_q   <= 4'd0;
            sel_lat_q     <= {SEL_W{1'b0}};
            block_w_q     <= {BLK_W{1'b0}};
            block_order_q <= 4'd0;
            blk_valid_q   <= 1'b0;
            load_busy_q   <= 1'b0;
            err_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            order_lat_q   <= order_lat_d;
            sel_lat_q     <= sel_lat_d;
            block_w_q     <= block_w_d;
            block_order_q <= block_order_d;
            blk_valid_q   <= blk_valid_d;
            load_busy_q   <= load_busy_d;
            err_start_q   <= err_start_d;
        end
    end

    assign bus.LOAD_BUSY   = load_busy_q;
    assign bus.BLK_VALID   = blk_valid_q;
    assign bus.BLOCK_W     = block_w_q;
    assign bus.BLOCK_ORDER = block_order_q;
    assign bus.ERR_START   = err_start_q;
endmodule
